// File: rtl/fp_mult_pkg.sv
// Shared types and encoding helpers for the sequential floating-point multiplier.
// All helpers take the field widths as arguments so any EXP_W/MAN_W pair can use them.
package fp_mult_pkg;

  typedef enum logic [1:0] {IDLE, UNPACK, MULT, NORM} state_e;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} op_class_e;

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Encodings are built in 64 bits and narrowed by the user to the word width.
  function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
    return ((64'(1) << exp_w) - 64'(1)) << man_w;
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return ((64'(1) << (exp_w + 1)) - 64'(1)) << (man_w - 1);
  endfunction

endpackage

// File: rtl/fp_mult_mant.sv
// fp_mant_seq_mult: N x N unsigned shift-add multiplier, one multiplier bit per cycle.
// A start pulse loads the operands; done_o is high during the final step (N steps total).
module fp_mant_seq_mult #(
  parameter int N = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [N-1:0]     a_i,
  input  logic [N-1:0]     b_i,
  output logic             done_o,
  output logic [2*N-1:0]   product_o
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [2*N-1:0] mcand_q;
  logic [2*N-1:0] product_q;
  logic [N-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           active_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      active_q  <= 1'b0;
    end else if (start_i) begin
      mcand_q   <= {{N{1'b0}}, a_i};
      mplier_q  <= b_i;
      product_q <= '0;
      cnt_q     <= '0;
      active_q  <= 1'b1;
    end else if (active_q) begin
      if (mplier_q[0]) product_q <= product_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LAST) active_q <= 1'b0;
    end
  end

  assign done_o    = active_q && (cnt_q == LAST);
  assign product_o = product_q;

endmodule

// File: rtl/fp_multiply_seq.sv
// Sequential floating-point multiplier with fixed MAN_W+3 cycle latency and DAZ/FTZ behaviour.
// Define ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates toward zero.
module fp_multiply_seq
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] in_A,
  input  logic [EXP_W+MAN_W:0] in_B,
  input  logic                 in_En,
  output logic [EXP_W+MAN_W:0] out_Out,
  output logic                 out_Ready,
  output logic                 out_Busy,
  output logic                 out_Ovf,
  output logic                 out_Unf
);

  localparam int W   = fp_width(EXP_W, MAN_W);
  localparam int N   = MAN_W + 1;
  localparam int EW2 = EXP_W + 2;
  localparam logic [W-1:0]          QNAN    = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0]          INF_MAG = W'(fp_inf(EXP_W, MAN_W));
  localparam logic signed [EW2-1:0] BIAS    = EW2'(fp_bias(EXP_W));
  localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);

  state_e                 state_q;
  logic [W-1:0]           a_q, b_q, out_q, res_d;
  op_class_e              cls_a_q, cls_b_q;
  logic                   sign_q, ready_q, busy_q, ovf_q, unf_q, ovf_d, unf_d;
  logic signed [EW2-1:0]  exp_q, exp_r;
  logic                   mult_start, mult_done, norm_shift, carry;
  logic [2*N-1:0]         product, prod_n;
  logic [MAN_W-1:0]       frac_t, frac_r;
`ifdef ROUND_NEAREST_EN
  logic                   guard_b, round_b, sticky_b;
`endif

  // Subnormals classify as zero (denormals-are-zero).
  function automatic op_class_e classify(input logic [W-2:0] x);
    if (x[W-2 -: EXP_W] == '0) return ZERO;
    if (x[W-2 -: EXP_W] == '1) return (x[MAN_W-1:0] == '0) ? INF : NAN;
    return NORMAL;
  endfunction

  assign mult_start = (state_q == UNPACK);

  fp_mant_seq_mult #(.N(N)) u_mant (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mult_start),
    .a_i       ({1'b1, a_q[MAN_W-1:0]}),
    .b_i       ({1'b1, b_q[MAN_W-1:0]}),
    .done_o    (mult_done),
    .product_o (product)
  );

  always_comb begin
    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    res_d      = '0;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    norm_shift = product[2*N-1];
    prod_n     = norm_shift ? product : (product << 1);
    frac_t     = MAN_W'(prod_n >> N);
`ifdef ROUND_NEAREST_EN
    guard_b  = prod_n[N-1];
    round_b  = prod_n[N-2];
    sticky_b = |prod_n[N-3:0];
    {carry, frac_r} = {1'b0, frac_t} + N'(guard_b & (round_b | sticky_b | frac_t[0]));
`else
    carry  = 1'b0;
    frac_r = frac_t;
`endif
    exp_r = exp_q + EW2'(norm_shift) + EW2'(carry);

    if (cls_a_q == NAN || cls_b_q == NAN ||
        (cls_a_q == INF && cls_b_q == ZERO) || (cls_a_q == ZERO && cls_b_q == INF)) begin
      res_d = QNAN;
    end else if (cls_a_q == INF || cls_b_q == INF) begin
      res_d = {sign_q, INF_MAG[W-2:0]};
    end else if (cls_a_q == ZERO || cls_b_q == ZERO) begin
      res_d = {sign_q, {(W-1){1'b0}}};
    end else if (exp_r >= EXP_MAX) begin
      res_d = {sign_q, INF_MAG[W-2:0]};
      ovf_d = 1'b1;
    end else if (exp_r[EW2-1] || exp_r == '0) begin
      res_d = {sign_q, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end else begin
      res_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cls_a_q <= ZERO;
      cls_b_q <= ZERO;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: if (in_En) begin
          a_q     <= in_A;
          b_q     <= in_B;
          busy_q  <= 1'b1;
          ovf_q   <= 1'b0;
          unf_q   <= 1'b0;
          state_q <= UNPACK;
        end
        UNPACK: begin
          cls_a_q <= classify(a_q[W-2:0]);
          cls_b_q <= classify(b_q[W-2:0]);
          sign_q  <= a_q[W-1] ^ b_q[W-1];
          exp_q   <= EW2'(a_q[W-2 -: EXP_W]) + EW2'(b_q[W-2 -: EXP_W]) - BIAS;
          state_q <= MULT;
        end
        MULT: if (mult_done) state_q <= NORM;
        NORM: begin
          out_q   <= res_d;
          ovf_q   <= ovf_d;
          unf_q   <= unf_d;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_Out   = out_q;
  assign out_Ready = ready_q;
  assign out_Busy  = busy_q;
  assign out_Ovf   = ovf_q;
  assign out_Unf   = unf_q;

endmodule

// File: tb/tb_fp_multiply_seq.sv
// Scoreboard bench for fp_multiply_seq: half-precision and single-precision instances,
// directed corner cases plus random operands checked against an arithmetic reference model.
module tb_fp_multiply_seq;

  typedef struct { logic [63:0] res; logic ovf; logic unf; int cyc; } exp_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] r; logic ovf; logic unf; } dir_t;

  localparam int LAT16 = 10 + 3;
  localparam int LAT32 = 23 + 3;
`ifdef ROUND_NEAREST_EN
  localparam logic [15:0] RND_RES = 16'h3E02;
`else
  localparam logic [15:0] RND_RES = 16'h3E01;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_A, in_B, out_Out;
  logic        in_En, out_Ready, out_Busy, out_Ovf, out_Unf;
  logic [31:0] w_a, w_b, w_out;
  logic        w_en, w_ready, w_busy, w_ovf, w_unf;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_ready = 0;
  exp_t sb[$];
  exp_t sbw[$];

  dir_t dirs [10] = '{
    '{16'h0000, 16'h5010, 16'h0000, 1'b0, 1'b0},
    '{16'h3E00, 16'h3C01, RND_RES,  1'b0, 1'b0},
    '{16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1, 1'b0},
    '{16'h0400, 16'h0400, 16'h0000, 1'b0, 1'b1},
    '{16'h7C00, 16'h0000, 16'h7E00, 1'b0, 1'b0},
    '{16'hFC00, 16'h4000, 16'hFC00, 1'b0, 1'b0},
    '{16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 1'b0},
    '{16'h7E00, 16'h3C00, 16'h7E00, 1'b0, 1'b0},
    '{16'h0001, 16'h3C00, 16'h0000, 1'b0, 1'b0},
    '{16'h8001, 16'h3C00, 16'h8000, 1'b0, 1'b0}
  };

  fp_multiply_seq dut (
    .clk(clk), .rst(rst), .in_A(in_A), .in_B(in_B), .in_En(in_En),
    .out_Out(out_Out), .out_Ready(out_Ready), .out_Busy(out_Busy),
    .out_Ovf(out_Ovf), .out_Unf(out_Unf)
  );

  fp_multiply_seq #(.EXP_W(8), .MAN_W(23)) dut_w (
    .clk(clk), .rst(rst), .in_A(w_a), .in_B(w_b), .in_En(w_en),
    .out_Out(w_out), .out_Ready(w_ready), .out_Busy(w_busy),
    .out_Ovf(w_ovf), .out_Unf(w_unf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: exact integer product of the significands, then rounding by remainder comparison.
  function automatic exp_t model(input int ew, input int mw, input logic [63:0] a, input logic [63:0] b);
    exp_t r;
    logic [63:0] fmask, emax, fa, fb, ea, eb, prod, q, sgn, inf, qnan;
`ifdef ROUND_NEAREST_EN
    logic [63:0] rem, half;
`endif
    int e, sh;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    fmask = (64'(1) << mw) - 1;
    emax  = (64'(1) << ew) - 1;
    fa = a & fmask;  ea = (a >> mw) & emax;
    fb = b & fmask;  eb = (b >> mw) & emax;
    a_nan = (ea == emax) && (fa != 0);  a_inf = (ea == emax) && (fa == 0);  a_zero = (ea == 0);
    b_nan = (eb == emax) && (fb != 0);  b_inf = (eb == emax) && (fb == 0);  b_zero = (eb == 0);
    sgn  = 64'(a[ew+mw] ^ b[ew+mw]) << (ew + mw);
    inf  = emax << mw;
    qnan = ((64'(1) << (ew + 1)) - 1) << (mw - 1);
    r.res = '0;  r.ovf = 1'b0;  r.unf = 1'b0;  r.cyc = 0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r.res = qnan;
    end else if (a_inf || b_inf) begin
      r.res = sgn | inf;
    end else if (a_zero || b_zero) begin
      r.res = sgn;
    end else begin
      prod = (fa | (64'(1) << mw)) * (fb | (64'(1) << mw));
      e = int'(ea) + int'(eb) - ((1 << (ew - 1)) - 1);
      sh = mw;
      if (prod >= (64'(1) << (2 * mw + 1))) begin sh = mw + 1; e++; end
      q = prod >> sh;
`ifdef ROUND_NEAREST_EN
      rem  = prod - (q << sh);
      half = 64'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q >= (64'(1) << (mw + 1))) begin q = q >> 1; e++; end
`endif
      if (e >= int'(emax)) begin r.res = sgn | inf; r.ovf = 1'b1; end
      else if (e <= 0) begin r.res = sgn; r.unf = 1'b1; end
      else r.res = sgn | (64'(e) << mw) | (q & fmask);
    end
    return r;
  endfunction

  // Random word, often steered towards zero/inf/NaN exponents or exponents near the bias.
  function automatic logic [63:0] rand_op(input int ew, input int mw);
    logic [63:0] v, emask;
    int k, bias;
    bias  = (1 << (ew - 1)) - 1;
    emask = ((64'(1) << ew) - 1) << mw;
    v = {32'($urandom), 32'($urandom)} & ((64'(1) << (ew + mw + 1)) - 1);
    k = $urandom_range(0, 9);
    if (k == 0)     v = v & ~emask;
    else if (k == 1) v = v | emask;
    else if (k < 7) v = (v & ~emask) | (64'(bias + int'($urandom_range(0, 6)) - 3) << mw);
    return v;
  endfunction

  task automatic wait_idle16();
    int n = 0;
    while (out_Busy && n < 100) begin @(negedge clk); n++; end
    check("idle_wait16", 64'(out_Busy), 0);
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input exp_t e);
    wait_idle16();
    in_A = a;  in_B = b;  in_En = 1'b1;
    e.cyc = cyc + 1 + LAT16;
    sb.push_back(e);
    @(negedge clk);
    in_En = 1'b0;
    check("busy_after_accept", 64'(out_Busy), 1);
    check("flags_cleared_on_accept", 64'({out_Ovf, out_Unf}), 0);
  endtask

  // in_En stays high for the whole first operation with different operands presented;
  // those must be ignored while busy and then accepted in the out_Ready cycle.
  task automatic issue16_held(input logic [15:0] a, input logic [15:0] b, input exp_t e,
                              input logic [15:0] a2, input logic [15:0] b2, input exp_t e2);
    wait_idle16();
    in_A = a;  in_B = b;  in_En = 1'b1;
    e.cyc = cyc + 1 + LAT16;
    sb.push_back(e);
    @(negedge clk);
    in_A = a2;  in_B = b2;
    check("busy_held_en", 64'(out_Busy), 1);
    wait_idle16();
    e2.cyc = cyc + 1 + LAT16;
    sb.push_back(e2);
    @(negedge clk);
    in_En = 1'b0;
    check("busy_back_to_back", 64'(out_Busy), 1);
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int n = 0;
    while (w_busy && n < 100) begin @(negedge clk); n++; end
    check("idle_wait32", 64'(w_busy), 0);
    w_a = a;  w_b = b;  w_en = 1'b1;
    e.cyc = cyc + 1 + LAT32;
    sbw.push_back(e);
    @(negedge clk);
    w_en = 1'b0;
    check("busy32_after_accept", 64'(w_busy), 1);
  endtask

  initial begin : mon16
    exp_t e;
    bit   prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev) check("ready_pulse_width", 64'(out_Ready), 0);
      prev = out_Ready;
      if (out_Ready) begin
        n_ready++;
        check("ready_has_expectation", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("result16", 64'(out_Out), e.res);
          check("ovf16", 64'(out_Ovf), 64'(e.ovf));
          check("unf16", 64'(out_Unf), 64'(e.unf));
          check("latency16", 64'(cyc), 64'(e.cyc));
          check("busy_low_at_ready", 64'(out_Busy), 0);
        end
      end
    end
  end

  initial begin : mon32
    exp_t e;
    bit   prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev) check("ready32_pulse_width", 64'(w_ready), 0);
      prev = w_ready;
      if (w_ready) begin
        check("ready32_has_expectation", 64'(sbw.size() != 0), 1);
        if (sbw.size() != 0) begin
          e = sbw.pop_front();
          check("result32", 64'(w_out), e.res);
          check("ovf32", 64'(w_ovf), 64'(e.ovf));
          check("unf32", 64'(w_unf), 64'(e.unf));
          check("latency32", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t        e, e2;
    logic [63:0] a, b;
    int          r0, n;
    rst = 1'b1;  in_En = 1'b0;  in_A = '0;  in_B = '0;
    w_en = 1'b0;  w_a = '0;  w_b = '0;
    #1;
    check("reset_out", 64'(out_Out), 0);
    check("reset_flags", 64'({out_Ready, out_Busy, out_Ovf, out_Unf}), 0);
    check("reset_out32", 64'(w_out), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (dirs[i]) begin
      e.res = 64'(dirs[i].r);  e.ovf = dirs[i].ovf;  e.unf = dirs[i].unf;  e.cyc = 0;
      issue16(dirs[i].a, dirs[i].b, e);
    end

    e.res  = 64'h0000_CA00;  e.ovf  = 1'b0;  e.unf  = 1'b0;  e.cyc  = 0;
    e2.res = 64'h0000_3C00;  e2.ovf = 1'b0;  e2.unf = 1'b0;  e2.cyc = 0;
    issue16_held(16'h4200, 16'hC400, e, 16'h3C00, 16'h3C00, e2);

    for (int i = 0; i < 60; i++) begin
      a = rand_op(5, 10);
      b = rand_op(5, 10);
      issue16(a[15:0], b[15:0], model(5, 10, a, b));
    end

    // Abort an operation with an asynchronous reset after a nonzero result is on the output.
    e.res = 64'h0000_4000;  e.ovf = 1'b0;  e.unf = 1'b0;  e.cyc = 0;
    issue16(16'h3C00, 16'h4000, e);
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("out_nonzero_before_reset", 64'(out_Out), 64'h4000);
    in_A = 16'h4200;  in_B = 16'h4200;  in_En = 1'b1;
    @(negedge clk);
    in_En = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_zero", 64'(out_Out), 0);
    check("abort_status_zero", 64'({out_Ready, out_Busy, out_Ovf, out_Unf}), 0);
    @(negedge clk);
    rst = 1'b0;
    r0 = n_ready;
    repeat (20) @(negedge clk);
    check("no_ready_after_abort", 64'(n_ready - r0), 0);

    e.ovf = 1'b0;  e.unf = 1'b0;  e.cyc = 0;
    e.res = 64'h4000_0000;  issue32(32'h3F80_0000, 32'h4000_0000, e);
    e.res = 64'hC140_0000;  issue32(32'h4040_0000, 32'hC080_0000, e);
    e.res = 64'h7FC0_0000;  issue32(32'h7F80_0000, 32'h0000_0000, e);
    e.res = 64'hFF80_0000;  issue32(32'hFF80_0000, 32'h4000_0000, e);
    for (int i = 0; i < 12; i++) begin
      a = rand_op(8, 23);
      b = rand_op(8, 23);
      issue32(a[31:0], b[31:0], model(8, 23, a, b));
    end

    n = 0;
    while ((sb.size() != 0 || sbw.size() != 0) && n < 400) begin @(negedge clk); n++; end
    check("drain16", 64'(sb.size()), 0);
    check("drain32", 64'(sbw.size()), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
